axi_write_arbiter: RTL

- Write-path arbiter and sequencer for the two-master AXI interconnect (M0 CPU-side, M1 DMA-side).
- Grants the single shared write path to one master at a time and decodes the target slave (S1 IM, S2 DM, S3 sensor ctrl, S4 DRAM, or default/DECERR).
- Steps the transaction through AW, W and B phases and drives the write-state and AWID-control selects consumed by the AW/W/B channel muxes.
- Acts as the default slave for unmapped and ROM addresses, including the ROM region at 0x0000_xxxx.

---
 rtl/axi_write_arbiter_if.sv | 53 +++++
 rtl/axi_write_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/axi_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// axi_write_arbiter_if
// Bundles the write-path control signals seen by the two-master write
// arbiter: per-master AW/W/B handshake inputs, per-slave ready/valid vectors,
// and the arbiter's select and default-slave outputs.
//   master modport : the side that drives masters/slaves (interconnect fabric
//                    or testbench)
//   slave modport  : the arbiter's own view
// Slave vectors are ordered S4..S1 with bit0 = S1.
// ---------------------------------------------------------------------------
interface axi_write_arbiter_if;
  logic        AWVALID_M0;
  logic [31:0] AWADDR_M0;
  logic [3:0]  AWLEN_M0;
  logic        AWVALID_M1;
  logic [31:0] AWADDR_M1;
  logic [3:0]  AWLEN_M1;
  logic        WVALID_M0;
  logic        WVALID_M1;
  logic        WLAST_M0;
  logic        WLAST_M1;
  logic        BREADY_M0;
  logic        BREADY_M1;
  logic [3:0]  AWREADY_S;
  logic [3:0]  WREADY_S;
  logic [3:0]  BVALID_S;
  logic [1:0]  Arbiter_Write_State_control;
  logic [3:0]  Arbiter_AWID_control;
  logic        def_awready;
  logic        def_wready;
  logic        def_bvalid;
  logic        wlen_err;

  modport master (
    output AWVALID_M0, AWADDR_M0, AWLEN_M0,
    output AWVALID_M1, AWADDR_M1, AWLEN_M1,
    output WVALID_M0, WVALID_M1, WLAST_M0, WLAST_M1,
    output BREADY_M0, BREADY_M1,
    output AWREADY_S, WREADY_S, BVALID_S,
    input  Arbiter_Write_State_control, Arbiter_AWID_control,
    input  def_awready, def_wready, def_bvalid, wlen_err
  );

  modport slave (
    input  AWVALID_M0, AWADDR_M0, AWLEN_M0,
    input  AWVALID_M1, AWADDR_M1, AWLEN_M1,
    input  WVALID_M0, WVALID_M1, WLAST_M0, WLAST_M1,
    input  BREADY_M0, BREADY_M1,
    input  AWREADY_S, WREADY_S, BVALID_S,
    output Arbiter_Write_State_control, Arbiter_AWID_control,
    output def_awready, def_wready, def_bvalid, wlen_err
  );
endinterface

// File: rtl/axi_write_arbiter.sv
// ---------------------------------------------------------------------------
// axi_write_arbiter
// Grants the shared AXI write path to M0 (CPU) or M1 (DMA), decodes the
// target slave, and sequences AW -> W -> B. Also acts as the default slave
// (DECERR target) for unmapped/ROM addresses.
// Ports:
//   ACLK   : clock
//   ARESET : synchronous active-high reset
//   bus    : axi_write_arbiter_if.slave
//            Arbiter_Write_State_control 00 IDLE / 01 ADDR / 10 DATA / 11 RESP
//            Arbiter_AWID_control {master, slave[2:0]}, slave 1..4 = S1..S4,
//            5 = default, 4'h0 = no grant
//            def_awready/def_wready/def_bvalid : default-slave handshakes
//            wlen_err : one-cycle pulse when WLAST beat count != AWLEN
// ---------------------------------------------------------------------------
module axi_write_arbiter #(
  parameter logic [15:0] S1_BASE = 16'h0001,
  parameter logic [15:0] S2_BASE = 16'h0002,
  parameter logic [15:0] S3_BASE = 16'h1000,
  parameter logic [10:0] S4_BASE = 11'h100
) (
  input logic              ACLK,
  input logic              ARESET,
  axi_write_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10,
    RESP = 2'b11
  } state_t;

  localparam logic [2:0] SLV_DEF = 3'd5;

  state_t     state, state_nxt;
  logic [3:0] ctrl, ctrl_nxt;
  logic       last_grant, last_grant_nxt;   // 0 = M0, 1 = M1
  logic [3:0] awlen_q, awlen_nxt;
  logic [3:0] beat_cnt, beat_cnt_nxt;
  logic       wlen_err_q, wlen_err_nxt;
  logic       def_awready_q, def_wready_q, def_bvalid_q;

  logic       win_m1;
  logic [2:0] win_slave;
  logic       gnt_m1;
  logic [2:0] gnt_slave;
  logic       aw_valid_sel, w_valid_sel, w_last_sel, b_ready_sel;
  logic [3:0] aw_len_sel;
  logic       aw_ready_sel, w_ready_sel, b_valid_sel;

  // Address decode on the upper address bits; priority S1, S2, S3, S4.
  function automatic logic [2:0] decode(input logic [15:0] hi);
    if (hi == S1_BASE)            decode = 3'd1;
    else if (hi == S2_BASE)       decode = 3'd2;
    else if (hi == S3_BASE)       decode = 3'd3;
    else if (hi[15:5] == S4_BASE) decode = 3'd4;
    else                          decode = SLV_DEF;
  endfunction

  // Picks the selected slave's bit from an S4..S1 vector, or the default
  // slave's own signal for slave 5.
  function automatic logic pick(input logic [3:0] vec, input logic [2:0] slv,
                                input logic dflt);
    case (slv)
      3'd1:    pick = vec[0];
      3'd2:    pick = vec[1];
      3'd3:    pick = vec[2];
      3'd4:    pick = vec[3];
      3'd5:    pick = dflt;
      default: pick = 1'b0;
    endcase
  endfunction

  assign gnt_m1    = ctrl[3];
  assign gnt_slave = ctrl[2:0];

  // Route the granted master's and selected slave's handshake signals.
  always_comb begin
    aw_valid_sel = gnt_m1 ? bus.AWVALID_M1 : bus.AWVALID_M0;
    aw_len_sel   = gnt_m1 ? bus.AWLEN_M1   : bus.AWLEN_M0;
    w_valid_sel  = gnt_m1 ? bus.WVALID_M1  : bus.WVALID_M0;
    w_last_sel   = gnt_m1 ? bus.WLAST_M1   : bus.WLAST_M0;
    b_ready_sel  = gnt_m1 ? bus.BREADY_M1  : bus.BREADY_M0;
    aw_ready_sel = pick(bus.AWREADY_S, gnt_slave, def_awready_q);
    w_ready_sel  = pick(bus.WREADY_S,  gnt_slave, def_wready_q);
    b_valid_sel  = pick(bus.BVALID_S,  gnt_slave, def_bvalid_q);
  end

  // Round-robin choice and same-cycle decode of the winner's address.
  always_comb begin
    if (bus.AWVALID_M0 && bus.AWVALID_M1) begin
      win_m1 = ~last_grant;
    end else begin
      win_m1 = bus.AWVALID_M1;
    end
    win_slave = decode(win_m1 ? bus.AWADDR_M1[31:16] : bus.AWADDR_M0[31:16]);
  end

  // Next-state and next-register logic for the AW/W/B sequencer.
  always_comb begin
    state_nxt      = state;
    ctrl_nxt       = ctrl;
    last_grant_nxt = last_grant;
    awlen_nxt      = awlen_q;
    beat_cnt_nxt   = beat_cnt;
    wlen_err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.AWVALID_M0 || bus.AWVALID_M1) begin
          ctrl_nxt  = {win_m1, win_slave};
          state_nxt = ADDR;
        end else begin
          ctrl_nxt  = 4'h0;
        end
      end
      ADDR: begin
        if (aw_valid_sel && aw_ready_sel) begin
          awlen_nxt    = aw_len_sel;
          beat_cnt_nxt = 4'd0;
          state_nxt    = DATA;
        end else begin
          state_nxt    = ADDR;
        end
      end
      DATA: begin
        if (w_valid_sel && w_ready_sel) begin
          beat_cnt_nxt = beat_cnt + 4'd1;
          if (w_last_sel) begin
            wlen_err_nxt = (beat_cnt != awlen_q);
            state_nxt    = RESP;
          end else begin
            state_nxt    = DATA;
          end
        end else begin
          state_nxt = DATA;
        end
      end
      RESP: begin
        if (b_valid_sel && b_ready_sel) begin
          last_grant_nxt = gnt_m1;
          ctrl_nxt       = 4'h0;
          state_nxt      = IDLE;
        end else begin
          state_nxt      = RESP;
        end
      end
      default: begin
        state_nxt = IDLE;
        ctrl_nxt  = 4'h0;
      end
    endcase
  end

  // State and datapath registers; default-slave handshakes are registered
  // from the next state so they line up with the phase they belong to.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state         <= IDLE;
      ctrl          <= 4'h0;
      last_grant    <= 1'b1;
      awlen_q       <= 4'd0;
      beat_cnt      <= 4'd0;
      wlen_err_q    <= 1'b0;
      def_awready_q <= 1'b0;
      def_wready_q  <= 1'b0;
      def_bvalid_q  <= 1'b0;
    end else begin
      state         <= state_nxt;
      ctrl          <= ctrl_nxt;
      last_grant    <= last_grant_nxt;
      awlen_q       <= awlen_nxt;
      beat_cnt      <= beat_cnt_nxt;
      wlen_err_q    <= wlen_err_nxt;
      def_awready_q <= (state_nxt == ADDR) && (ctrl_nxt[2:0] == SLV_DEF);
      def_wready_q  <= (state_nxt == DATA) && (ctrl_nxt[2:0] == SLV_DEF);
      def_bvalid_q  <= (state_nxt == RESP) && (ctrl_nxt[2:0] == SLV_DEF);
    end
  end

  assign bus.Arbiter_Write_State_control = state;
  assign bus.Arbiter_AWID_control        = ctrl;
  assign bus.def_awready                 = def_awready_q;
  assign bus.def_wready                  = def_wready_q;
  assign bus.def_bvalid                  = def_bvalid_q;
  assign bus.wlen_err                    = wlen_err_q;

endmodule
